// File: rtl/display_scheduler.sv
// Four-digit multiplexed 7-segment scanner with PWM brightness and a
// double-buffered digit bank that is swapped only on frame boundaries.
module display_scheduler #(
  parameter logic [15:0] DIV  = 16'd250,
  parameter int unsigned DIVW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_req,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic       commit,
  output logic       commit_done,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig,
  output logic       frame_tick
);

  localparam logic [DIVW-1:0] TC = DIVW'(DIV - 16'd1);

  typedef enum logic [1:0] {IDLE, PEND, SWAP} state_t;

  state_t          state, state_n;
  logic [DIVW-1:0] presc;
  logic [2:0]      sub;
  logic [1:0]      slot;
  logic [2:0]      bright_l;
  logic [3:0][5:0] shadow_bank;  // {value, dp, blank}
  logic [3:0][5:0] active_bank;

  logic       step, sub_wrap, frame_wrap, slot_start, wr_en;
  logic [2:0] bright_eff;
  logic [5:0] sel_entry;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  assign step       = en && (presc == TC);
  assign sub_wrap   = step && (sub == 3'd7);
  assign frame_wrap = sub_wrap && (slot == 2'd3);
  assign slot_start = en && (presc == '0) && (sub == '0);
  assign bright_eff = slot_start ? bright : bright_l;
  assign wr_en      = wr_req && wr_ready;

  // During SWAP the slot-0 output is decoded from the shadow bank so the new
  // contents appear from the very first cycle of the frame.
  assign sel_entry = (state == SWAP) ? shadow_bank[slot] : active_bank[slot];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      sub      <= '0;
      slot     <= '0;
      bright_l <= '0;
    end else if (en) begin
      presc <= step ? '0 : presc + 1'b1;
      if (step)       sub      <= sub + 3'd1;
      if (sub_wrap)   slot     <= slot + 2'd1;
      if (slot_start) bright_l <= bright;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= '0;
      dp         <= 1'b0;
      dig        <= '0;
      frame_tick <= 1'b0;
    end else begin
      dig        <= (en && (sub <= bright_eff)) ? (4'b1000 >> slot) : 4'b0000;
      seg        <= (en && !sel_entry[0]) ? hex7(sel_entry[5:2]) : 7'b0000000;
      dp         <= en && !sel_entry[0] && sel_entry[1];
      frame_tick <= frame_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow_bank <= {4{6'b000001}};
      active_bank <= {4{6'b000001}};
    end else begin
      state <= state_n;
      if (wr_en)         shadow_bank[wr_digit] <= {wr_value, wr_dp, wr_blank};
      if (state == SWAP) active_bank           <= shadow_bank;
    end
  end

  always_comb begin
    state_n     = state;
    wr_ready    = 1'b0;
    commit_done = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (commit) state_n = PEND;
      end
      PEND: if (!en || frame_wrap) state_n = SWAP;
      SWAP: begin
        commit_done = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
